// File: rtl/io_pkg.sv
// Shared address map and status-register layout for the core-side store port.
// Software running on the core and the bench use the same constants.
package io_pkg;

  localparam logic [15:0] IO_DATA_ADDR = 16'hFF00;
  localparam logic [15:0] IO_STAT_ADDR = 16'hFF04;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_MSB = 15;
  localparam int ST_OVF_LSB   = 24;
  localparam int ST_OVF_MSB   = 31;

  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_FIFO = 2'd1,
    REGION_STAT = 2'd2
  } region_t;

  // Exact 16-bit match for the two IO words; everything else aliases into RAM.
  function automatic region_t decode_region(input logic [15:0] addr,
                                            input logic [15:0] data_addr,
                                            input logic [15:0] stat_addr);
    if (addr == data_addr)      return REGION_FIFO;
    else if (addr == stat_addr) return REGION_STAT;
    else                        return REGION_RAM;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with head-of-queue lookahead. A push while full is only
// accepted when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import io_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : storage[rd_ptr];

  // Storage holds data only; validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (push_ok) storage[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_store_port.sv
// Data-side port for the single-cycle core: word RAM, buffered output FIFO
// drained over valid/ready, and a readable status / overflow-clear register.
module io_store_port #(
  parameter int          DEPTH        = 8,
  parameter int          MEM_WORDS    = 64,
  parameter logic [15:0] IO_DATA_ADDR = io_pkg::IO_DATA_ADDR,
  parameter logic [15:0] IO_STAT_ADDR = io_pkg::IO_STAT_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [15:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  overflow_cnt
);
  import io_pkg::*;

  localparam int MW = $clog2(MEM_WORDS);
  localparam int AW = $clog2(DEPTH);

  region_t          region;
  logic [MW-1:0]    mem_idx;
  logic [31:0]      mem [MEM_WORDS];
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;
  logic             stat_clr;
  logic             dropped;
  logic [31:0]      status;

  assign region    = decode_region(address, IO_DATA_ADDR, IO_STAT_ADDR);
  assign mem_idx   = address[MW+1:2];
  assign fifo_push = we && (region == REGION_FIFO);
  assign fifo_pop  = out_valid && out_ready;
  assign stat_clr  = we && (region == REGION_STAT);
  assign dropped   = fifo_push && fifo_full && !fifo_pop;
  assign out_valid = !fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (write_data),
    .head  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (we && (region == REGION_RAM)) mem[mem_idx] <= write_data;
  end

  // A clear wins over a simultaneous drop; the counter sticks at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_cnt <= 8'd0;
    end else if (stat_clr) begin
      overflow_cnt <= 8'd0;
    end else if (dropped && (overflow_cnt != 8'hFF)) begin
      overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

  always_comb begin
    status = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_COUNT_MSB:ST_COUNT_LSB] = 8'(fifo_count);
    status[ST_OVF_MSB:ST_OVF_LSB]     = overflow_cnt;
  end

  always_comb begin
    read_data = '0;
    case (region)
      REGION_FIFO: read_data = out_data;
      REGION_STAT: read_data = status;
      default:     read_data = mem[mem_idx];
    endcase
  end

endmodule

// File: tb/tb_io_store_port.sv
// Self-checking bench for io_store_port: vector table for decode/RAM,
// queue scoreboard for FIFO ordering, hand sequences for full/overflow/reset.
module tb_io_store_port;
  import io_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [15:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  overflow_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] sb_q[$];
  logic [7:0]  ovf_m = 8'd0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  io_store_port #(
    .DEPTH     (DEPTH),
    .MEM_WORDS (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we           (we),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_model();
    logic [31:0] s;
    int n;
    n = sb_q.size();
    s = '0;
    s[ST_EMPTY] = (n == 0);
    s[ST_FULL]  = (n == DEPTH);
    s[ST_COUNT_MSB:ST_COUNT_LSB] = 8'(n);
    s[ST_OVF_MSB:ST_OVF_LSB]     = ovf_m;
    return s;
  endfunction

  // One clock with the currently driven inputs; scoreboard pops are checked
  // before the edge, the overflow counter after it.
  task automatic cyc();
    bit pop_m;
    pop_m = out_ready && (sb_q.size() > 0);
    chk("out_valid", {31'b0, out_valid}, {31'b0, sb_q.size() > 0});
    if (pop_m) begin
      chk("out_data_pop", out_data, sb_q[0]);
      void'(sb_q.pop_front());
    end
    if (we && address == IO_DATA_ADDR) begin
      if (sb_q.size() < DEPTH) sb_q.push_back(write_data);
      else if (ovf_m != 8'hFF) ovf_m++;
    end
    if (we && address == IO_STAT_ADDR) ovf_m = 8'd0;
    @(posedge clk);
    #1;
    chk("overflow_cnt", {24'b0, overflow_cnt}, {24'b0, ovf_m});
  endtask

  task automatic store(input logic [15:0] a, input logic [31:0] d);
    we = 1'b1;
    address = a;
    write_data = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic read_stat(input string name, input logic [31:0] exp);
    address = IO_STAT_ADDR;
    #1;
    chk(name, read_data, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    we = 1'b0;
    address = 16'h0000;
    write_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_overflow", {24'b0, overflow_cnt}, 32'h0);

    vecs[0] = '{1'b0, IO_STAT_ADDR, 32'h0,        1'b1, 32'h0000_0001};
    vecs[1] = '{1'b1, 16'h0010,     32'hDEADBEEF, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 16'h0010,     32'h0,        1'b1, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 16'h0110,     32'h0,        1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 16'h0007,     32'h1234_5678, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 16'h0004,     32'h0,        1'b1, 32'h1234_5678};
    vecs[6] = '{1'b0, 16'hA013,     32'h0,        1'b1, 32'hDEADBEEF};
    vecs[7] = '{1'b0, IO_DATA_ADDR, 32'h0,        1'b1, 32'h0};

    for (int i = 0; i < 8; i++) begin
      we = vecs[i].we;
      address = vecs[i].addr;
      write_data = vecs[i].wdata;
      #1;
      if (vecs[i].chk) chk($sformatf("vec%0d_read", i), read_data, vecs[i].exp_rd);
      cyc();
      we = 1'b0;
    end

    // Fill to full with the sink stalled, then one dropped store.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) store(IO_DATA_ADDR, 32'(i));
    read_stat("stat_full", 32'h0000_0802);
    store(IO_DATA_ADDR, 32'd9);
    chk("ovf_after_drop", {24'b0, overflow_cnt}, 32'h1);
    address = IO_DATA_ADDR;
    #1;
    chk("head_after_drop", read_data, 32'h1);
    read_stat("stat_full_ovf", 32'h0100_0802);
    out_ready = 1'b1;
    idle(8);
    chk("drained_valid", {31'b0, out_valid}, 32'h0);
    read_stat("stat_drained", 32'h0100_0001);
    store(IO_STAT_ADDR, 32'hFFFF_FFFF);
    read_stat("stat_cleared", 32'h0000_0001);

    // Push into a full FIFO while the sink pops the head.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(IO_DATA_ADDR, 32'h100 + 32'(i));
    out_ready = 1'b1;
    store(IO_DATA_ADDR, 32'hA5);
    out_ready = 1'b0;
    read_stat("stat_push_pop_full", 32'h0000_0802);
    out_ready = 1'b1;
    idle(8);
    chk("sb_empty_after_a5", 32'(sb_q.size()), 32'h0);
    read_stat("stat_after_a5", stat_model());

    // Saturate the drop counter, then clear it.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(IO_DATA_ADDR, 32'h200 + 32'(i));
    for (int i = 0; i < 300; i++) store(IO_DATA_ADDR, 32'hBAD0_0000 + 32'(i));
    chk("ovf_saturated", {24'b0, overflow_cnt}, 32'hFF);
    read_stat("stat_saturated", 32'hFF00_0802);
    store(IO_STAT_ADDR, 32'h0);
    chk("ovf_clear", {24'b0, overflow_cnt}, 32'h0);
    out_ready = 1'b1;
    idle(8);

    // Asynchronous reset between edges discards queued words.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(IO_DATA_ADDR, 32'h300 + 32'(i));
    read_stat("stat_three", 32'h0000_0300);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("async_rst_data", out_data, 32'h0);
    sb_q.delete();
    ovf_m = 8'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    read_stat("stat_after_rst", 32'h0000_0001);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
